// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between the CPU datapath and a host requester,
// stalling the CPU one cycle per host access. Optional MEM_ARB_STARVE_GUARD_EN bounds host wait.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run_en,
    input  logic       i_cpu_mem_read,
    input  logic       i_cpu_mem_write,
    input  logic [7:0] i_cpu_addr,
    input  logic [7:0] i_cpu_wdata,
    output logic [7:0] o_cpu_rdata,
    output logic       o_cpu_en,
    input  logic       i_host_req,
    input  logic       i_host_we,
    input  logic [7:0] i_host_addr,
    input  logic [7:0] i_host_wdata,
    output logic       o_host_gnt,
    output logic       o_host_done,
    output logic [7:0] o_host_rdata,
    output logic [7:0] o_ram_addr,
    output logic [7:0] o_ram_wdata,
    output logic       o_ram_read,
    output logic       o_ram_write,
    input  logic [7:0] i_ram_rdata
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOST  = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t            r_state;
    logic [7:0]        r_host_rdata;
    logic [WAIT_W-1:0] w_wait_cnt;
    logic              w_starve;
    logic              w_cpu_uses_mem;
    logic              w_take_host;
    logic              w_in_host;

    // Holding reset low masks the HOST state so an in-flight host access is aborted.
    assign w_in_host      = (r_state == ST_HOST) && i_reset;
    assign w_cpu_uses_mem = i_cpu_mem_read || i_cpu_mem_write;
    assign w_starve       = (w_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_take_host    = i_host_req && (!i_run_en || !w_cpu_uses_mem || w_starve);

    assign o_cpu_en     = i_reset && !w_in_host && i_run_en;
    assign o_host_gnt   = w_in_host;
    assign o_host_done  = w_in_host;
    assign o_host_rdata = r_host_rdata;
    assign o_cpu_rdata  = i_ram_rdata;
    assign o_ram_addr   = w_in_host ? i_host_addr  : i_cpu_addr;
    assign o_ram_wdata  = w_in_host ? i_host_wdata : i_cpu_wdata;
    assign o_ram_read   = w_in_host ? !i_host_we   : (i_cpu_mem_read  && o_cpu_en);
    assign o_ram_write  = w_in_host ?  i_host_we   : (i_cpu_mem_write && o_cpu_en);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= ST_RUN;
            r_host_rdata <= 8'h00;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_take_host) begin
                        r_state <= ST_HOST;
                    end
                end
                ST_HOST: begin
                    r_state <= ST_GUARD;
                    if (!i_host_we) begin
                        r_host_rdata <= i_ram_rdata;
                    end
                end
                ST_GUARD: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [WAIT_W-1:0] r_wait_cnt;

    // Counts RUN cycles a request has been refused; saturates so the grant condition stays true.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_host_req && !w_take_host && !w_starve) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_HOST: r_wait_cnt <= '0;
                default: r_wait_cnt <= r_wait_cnt;
            endcase
        end
    end

    assign w_wait_cnt = r_wait_cnt;
`else
    assign w_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM and PC stand-in.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       runEn;
    logic       cpuMemRead;
    logic       cpuMemWrite;
    logic [7:0] cpuAddr;
    logic [7:0] cpuWdata;
    logic [7:0] cpuRdata;
    logic       cpuEn;
    logic       hostReq;
    logic       hostWe;
    logic [7:0] hostAddr;
    logic [7:0] hostWdata;
    logic       hostGnt;
    logic       hostDone;
    logic [7:0] hostRdata;
    logic [7:0] ramAddr;
    logic [7:0] ramWdata;
    logic       ramRead;
    logic       ramWrite;
    logic [7:0] ramRdata;

    logic [7:0] mem [256] = '{default: 8'h00};
    int         wrCount [256] = '{default: 0};
    logic [7:0] pc;

    int totalChecks = 0;
    int badChecks   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(4)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_run_en       (runEn),
        .i_cpu_mem_read (cpuMemRead),
        .i_cpu_mem_write(cpuMemWrite),
        .i_cpu_addr     (cpuAddr),
        .i_cpu_wdata    (cpuWdata),
        .o_cpu_rdata    (cpuRdata),
        .o_cpu_en       (cpuEn),
        .i_host_req     (hostReq),
        .i_host_we      (hostWe),
        .i_host_addr    (hostAddr),
        .i_host_wdata   (hostWdata),
        .o_host_gnt     (hostGnt),
        .o_host_done    (hostDone),
        .o_host_rdata   (hostRdata),
        .o_ram_addr     (ramAddr),
        .o_ram_wdata    (ramWdata),
        .o_ram_read     (ramRead),
        .o_ram_write    (ramWrite),
        .i_ram_rdata    (ramRdata)
    );

    // Stand-in for ram_256B (combinational read) and the ProgramCounter.
    assign ramRdata = ramRead ? mem[ramAddr] : 8'h00;

    always @(posedge clk) begin
        if (ramWrite) begin
            mem[ramAddr]     <= ramWdata;
            wrCount[ramAddr] <= wrCount[ramAddr] + 1;
        end
        if (!reset) pc <= 8'd0;
        else if (cpuEn) pc <= pc + 8'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ren, input logic mr, input logic mw,
                                 input logic [7:0] ca, input logic [7:0] cw, input logic hr,
                                 input logic hw, input logic [7:0] ha, input logic [7:0] hwd);
        reset = rst; runEn = ren; cpuMemRead = mr; cpuMemWrite = mw;
        cpuAddr = ca; cpuWdata = cw; hostReq = hr; hostWe = hw; hostAddr = ha; hostWdata = hwd;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pc0;
    logic [7:0] k;
    logic [7:0] idx;
    logic [8:0] gntMask;
    logic       prevGnt;
    logic       hr;
    int         firstGnt;
    int         gntCount;
    int         numCycles;

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 8'h34, 1'b1, 1'b1, 8'h3C, 8'hEE);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 8'h34, 1'b1, 1'b1, 8'h3C, 8'hEE);
            checkOutput("rst_cpu_en", cpuEn, 0);
            checkOutput("rst_gnt", hostGnt, 0);
            checkOutput("rst_done", hostDone, 0);
            checkOutput("rst_ram_write", ramWrite, 0);
            checkOutput("rst_ram_read", ramRead, 0);
            checkOutput("rst_ram_addr", ramAddr, 8'h21);
            checkOutput("rst_host_rdata", hostRdata, 8'h00);
        end
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("post_rst_cpu_en", cpuEn, 1);
        checkOutput("post_rst_gnt", hostGnt, 0);

        // Idle host write then read-back with the CPU halted.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 8'hA5);
        checkOutput("wr_req_gnt", hostGnt, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3C, 8'hA5);
        checkOutput("wr_gnt", hostGnt, 1);
        checkOutput("wr_done", hostDone, 1);
        checkOutput("wr_ram_write", ramWrite, 1);
        checkOutput("wr_ram_read", ramRead, 0);
        checkOutput("wr_ram_addr", ramAddr, 8'h3C);
        checkOutput("wr_ram_wdata", ramWdata, 8'hA5);
        checkOutput("wr_cpu_en", cpuEn, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("wr_guard_gnt", hostGnt, 0);
        checkOutput("wr_mem", mem[8'h3C], 8'hA5);
        checkOutput("wr_rdata_hold", hostRdata, 8'h00);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h00);
        checkOutput("rd_req_gnt", hostGnt, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C, 8'h00);
        checkOutput("rd_gnt", hostGnt, 1);
        checkOutput("rd_ram_read", ramRead, 1);
        checkOutput("rd_cpu_rdata", cpuRdata, 8'hA5);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("rd_host_rdata", hostRdata, 8'hA5);

        // Cycle stealing during an ALU-only instruction stream.
        nextCycle();
        pc0 = pc;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h55);
        checkOutput("steal_req_cpu_en", cpuEn, 1);
        checkOutput("steal_req_gnt", hostGnt, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h55);
        checkOutput("steal_cpu_en", cpuEn, 0);
        checkOutput("steal_gnt", hostGnt, 1);
        checkOutput("steal_pc_a", pc, pc0 + 8'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("steal_guard_cpu_en", cpuEn, 1);
        checkOutput("steal_pc_held", pc, pc0 + 8'd1);
        checkOutput("steal_mem", mem[8'h10], 8'h55);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("steal_pc_resume", pc, pc0 + 8'd2);

        // Memory-heavy CPU: odd instructions store, even ones load; instruction index follows the PC.
`ifdef MEM_ARB_STARVE_GUARD_EN
        numCycles = 10;
`else
        numCycles = 20;
`endif
        firstGnt = -1;
        gntCount = 0;
        pc0 = 8'd0;
        for (int c = 0; c < numCycles; c++) begin
            nextCycle();
            if (c == 0) pc0 = pc;
            k = pc - pc0;
            applyStimulus(1'b1, 1'b1, !k[0], k[0], 8'h80 + k, k + 8'd1,
                          (firstGnt < 0), 1'b0, 8'h40, 8'h00);
            if (hostGnt) begin
                gntCount++;
                if (firstGnt < 0) firstGnt = c;
            end
        end
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkOutput("starve_first_gnt", firstGnt, 5);
        checkOutput("starve_gnt_count", gntCount, 1);
        checkOutput("starve_pc_advance", pc - pc0, 9);
        checkOutput("starve_sw_once", wrCount[8'h85], 1);
        checkOutput("starve_sw_data", mem[8'h85], 8'h06);
        checkOutput("starve_host_rdata", hostRdata, 8'h00);
`else
        checkOutput("busy_gnt_count", gntCount, 0);
        checkOutput("busy_pc_advance", pc - pc0, 20);
        checkOutput("busy_sw_first", mem[8'h81], 8'h02);
        checkOutput("busy_sw_first_cnt", wrCount[8'h81], 1);
        checkOutput("busy_sw_last", mem[8'h93], 8'h14);
        checkOutput("busy_sw_last_cnt", wrCount[8'h93], 1);
`endif

        // Back-to-back host writes, each new request presented right after the previous done.
        idx = 8'd0;
        prevGnt = 1'b0;
        gntMask = '0;
        for (int c = 0; c < 9; c++) begin
            nextCycle();
            if (prevGnt) idx = idx + 8'd1;
            hr = (idx < 8'd3);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, hr, 1'b1, 8'h50 + idx, 8'h70 + idx);
            prevGnt = hostGnt;
            if (hostGnt) gntMask[c] = 1'b1;
        end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("b2b_gnt_mask", gntMask, 9'h092);
        for (int a = 0; a < 3; a++) begin
            checkOutput("b2b_wr_once", wrCount[8'h50 + a], 1);
            checkOutput("b2b_wr_data", mem[8'h50 + a], 8'h70 + a);
        end

        // Load host_rdata with a known value, then abort a host write with reset.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h51, 8'h00);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h51, 8'h00);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("pre_abort_rdata", hostRdata, 8'h71);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h99);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h99);
        checkOutput("abort_gnt_before", hostGnt, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h60, 8'h99);
        checkOutput("abort_gnt_forced", hostGnt, 0);
        checkOutput("abort_ram_write", ramWrite, 0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("abort_no_write", wrCount[8'h60], 0);
        checkOutput("abort_rdata_clear", hostRdata, 8'h00);
        checkOutput("abort_gnt_after", hostGnt, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
